session_controller: RTL

Sequencer that owns the shared load button and logout button for the password checker (`checkPassword`) and the prediction game. It routes button presses either as digit-load pulses to the checker or as load pulses to the game. It also enforces a failed-attempt lockout and an inactivity auto-logout. It sits between the board-level debounced buttons and the `checkPassword` and game blocks.

---
 rtl/session_pkg.sv | 30 +++
 rtl/rise_pulse.sv | 21 ++
 rtl/session_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/session_pkg.sv
// Shared types, default parameters and width helpers for the session controller.
package session_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StActive,
        StLogout,
        StLocked
    } session_state_t;

    localparam int unsigned DefPswdLen       = 4;
    localparam int unsigned DefCheckWait     = 16;
    localparam int unsigned DefMaxFails      = 3;
    localparam int unsigned DefLockoutCycles = 1000;
    localparam int unsigned DefIdleTimeout   = 5000;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector: registered history bit, edge = current sample high, previous low.
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic p
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign p = d & ~d_q;

endmodule

// File: rtl/session_controller.sv
// Routes shared load/logout buttons to the password checker or the game, with
// failed-attempt lockout and inactivity auto-logout.
module session_controller
    import session_pkg::*;
#(
    parameter int unsigned PSWD_LEN       = DefPswdLen,
    parameter int unsigned CHECK_WAIT     = DefCheckWait,
    parameter int unsigned MAX_FAILS      = DefMaxFails,
    parameter int unsigned LOCKOUT_CYCLES = DefLockoutCycles,
    parameter int unsigned IDLE_TIMEOUT   = DefIdleTimeout
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              Load_Button,
    input  logic                              Logout_Button,
    input  logic                              Authenticated,
    output logic                              Pswd_Load,
    output logic                              Game_Load,
    output logic                              Logout_Pulse,
    output logic                              Session_Active,
    output logic                              Locked,
    output logic [cnt_width(MAX_FAILS)-1:0]   Fail_Count
);

    localparam int unsigned TW = cnt_width(max3(CHECK_WAIT, LOCKOUT_CYCLES, IDLE_TIMEOUT));
    localparam int unsigned FW = cnt_width(MAX_FAILS);
    localparam int unsigned DW = cnt_width(PSWD_LEN);

    localparam logic [TW-1:0] CheckLast   = TW'(CHECK_WAIT - 1);
    localparam logic [TW-1:0] LockLast    = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] IdleLast    = TW'(IDLE_TIMEOUT - 1);
    localparam logic [FW-1:0] FailMax     = FW'(MAX_FAILS);
    localparam logic [DW-1:0] DigitLast   = DW'(PSWD_LEN - 1);

    session_state_t state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [DW-1:0]  digit_q, digit_d;
    logic [FW-1:0]  fail_q, fail_d;
    logic           timer_clr;
    logic           pswd_d, game_d, lpulse_d;
    logic           load_edge, logout_edge;

    rise_pulse u_load_rise (
        .clk (clk),
        .rst (rst),
        .d   (Load_Button),
        .p   (load_edge)
    );

    rise_pulse u_logout_rise (
        .clk (clk),
        .rst (rst),
        .d   (Logout_Button),
        .p   (logout_edge)
    );

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        fail_d    = fail_q;
        timer_clr = 1'b0;
        pswd_d    = 1'b0;
        game_d    = 1'b0;
        lpulse_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Authenticated) begin
                    state_d = StActive;
                    digit_d = '0;
                end else if (load_edge) begin
                    pswd_d = 1'b1;
                    if (digit_q == DigitLast) begin
                        state_d = StCheck;
                        digit_d = '0;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                // A match in the timeout cycle takes priority over the failure.
                if (Authenticated) begin
                    state_d = StActive;
                    fail_d  = '0;
                end else if (timer_q == CheckLast) begin
                    lpulse_d = 1'b1;
                    if (fail_q >= FailMax - FW'(1)) begin
                        fail_d  = FailMax;
                        state_d = StLocked;
                    end else begin
                        fail_d  = fail_q + 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StActive: begin
                if (logout_edge || timer_q == IdleLast) begin
                    state_d  = StLogout;
                    lpulse_d = 1'b1;
                end else if (!Authenticated) begin
                    state_d = StIdle;
                end else if (load_edge) begin
                    game_d    = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            StLogout: begin
                if (!Authenticated || timer_q == CheckLast) begin
                    state_d = StIdle;
                end
            end
            StLocked: begin
                if (timer_q == LockLast) begin
                    state_d = StIdle;
                    fail_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timer_clr || state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            digit_q        <= '0;
            fail_q         <= '0;
            Pswd_Load      <= 1'b0;
            Game_Load      <= 1'b0;
            Logout_Pulse   <= 1'b0;
            Session_Active <= 1'b0;
            Locked         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            digit_q        <= digit_d;
            fail_q         <= fail_d;
            Pswd_Load      <= pswd_d;
            Game_Load      <= game_d;
            Logout_Pulse   <= lpulse_d;
            Session_Active <= (state_d == StActive);
            Locked         <= (state_d == StLocked);
        end
    end

    assign Fail_Count = fail_q;

endmodule
